// File: rtl/if_fetch_axi_if.sv
// ---------------------------------------------------------------------------
// if_fetch_axi_if
//   AXI4-Lite read-only bus between the instruction-fetch stage (master) and
//   the instruction memory / interconnect (slave).
//
//   AR channel : m_araddr[31:0], m_arvalid, m_arready, m_arprot[2:0]
//   R  channel : m_rdata[31:0], m_rresp[1:0], m_rvalid, m_rready
// ---------------------------------------------------------------------------
interface if_fetch_axi_if;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [2:0]  m_arprot;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    modport master (
        output m_araddr, m_arvalid, m_arprot, m_rready,
        input  m_arready, m_rdata, m_rresp, m_rvalid
    );

    modport slave (
        input  m_araddr, m_arvalid, m_arprot, m_rready,
        output m_arready, m_rdata, m_rresp, m_rvalid
    );
endinterface

// File: rtl/if_fetch_axi.sv
// ---------------------------------------------------------------------------
// if_fetch_axi
//   Instruction-fetch stage feeding the IF/ID register. Owns the PC, fetches
//   one 32-bit word per transaction over AXI4-Lite, and presents it on
//   if_pc/if_inst while holding. Applies branch redirects from ID (after the
//   delay slot has been delivered) and exception redirects (flush), and
//   discards read data that a flush has made stale.
//
//   Ports
//     clk                   rising-edge clock
//     rst                   asynchronous active-low reset
//     stall[5:0]            pipeline stall vector, bit 0 holds IF
//     flush, new_pc         exception redirect (highest priority)
//     branch_flag_i,
//     branch_target_addr_i  taken branch/jump resolved in ID
//     axi                   AXI4-Lite read master
//     if_pc, if_inst        presented instruction (inst = 0 when not valid)
//     if_fetch_err          misaligned PC or non-OKAY response for if_pc
//     stallreq_if           fetch not complete, freeze IF/ID
// ---------------------------------------------------------------------------
module if_fetch_axi #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            stall,
    input  logic                  flush,
    input  logic [31:0]           new_pc,
    input  logic                  branch_flag_i,
    input  logic [31:0]           branch_target_addr_i,
    if_fetch_axi_if.master        axi,
    output logic [31:0]           if_pc,
    output logic [31:0]           if_inst,
    output logic                  if_fetch_err,
    output logic                  stallreq_if
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state_reg, state_next;

    logic [31:0] pc_reg;
    logic [31:0] araddr_reg;       // address of the read in flight
    logic [31:0] pend_target_reg;
    logic        pend_reg;
    logic        kill_reg;         // in-flight read was made stale by a flush
    logic [31:0] if_pc_reg;
    logic [31:0] inst_reg;
    logic        err_reg;

    logic        misaligned;
    logic        advance;
    logic        hold_entry;
    logic        hold_exit;
    logic        rsp_err;
    logic [31:0] pc_advance;

    // Only bit 0 of the stall vector concerns the fetch stage.
    logic        unused_stall;
    assign unused_stall = ^stall[5:1];

    assign misaligned = (pc_reg[1:0] != 2'b00);
    assign advance    = (state_reg == S_HOLD) && !stall[0] && !flush;
    assign hold_entry = (state_next == S_HOLD) && (state_reg != S_HOLD);
    assign hold_exit  = (state_reg == S_HOLD) && (state_next != S_HOLD);
    assign rsp_err    = (axi.m_rresp != 2'b00);

    // A branch seen in the advancing cycle beats one captured earlier.
    always_comb begin
        pc_advance = pc_reg + 32'd4;
        if (branch_flag_i) begin
            pc_advance = branch_target_addr_i;
        end else if (pend_reg) begin
            pc_advance = pend_target_reg;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                // A flush here retargets pc; re-evaluate it next cycle.
                if (flush) begin
                    state_next = S_IDLE;
                end else if (misaligned) begin
                    state_next = S_HOLD;
                end else begin
                    state_next = S_AR;
                end
            end
            S_AR: begin
                // The AR request cannot be withdrawn, even on flush.
                if (axi.m_arready) begin
                    state_next = S_R;
                end
            end
            S_R: begin
                if (axi.m_rvalid) begin
                    state_next = (kill_reg || flush) ? S_IDLE : S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush || !stall[0]) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        axi.m_arvalid = (state_reg == S_AR);
        axi.m_araddr  = araddr_reg;
        axi.m_arprot  = 3'b100;            // instruction, secure, unprivileged
        axi.m_rready  = (state_reg == S_R);
        stallreq_if   = (state_reg != S_HOLD);
        if_pc         = if_pc_reg;
        if_inst       = inst_reg;
        if_fetch_err  = err_reg;
    end

    // ---------------- PC, redirect and presentation registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg          <= RESET_PC;
            araddr_reg      <= RESET_PC;
            pend_reg        <= 1'b0;
            pend_target_reg <= 32'd0;
            kill_reg        <= 1'b0;
            if_pc_reg       <= RESET_PC;
            inst_reg        <= 32'd0;
            err_reg         <= 1'b0;
        end else begin
            // PC / pending branch: flush > advance > branch capture
            if (flush) begin
                pc_reg   <= new_pc;
                pend_reg <= 1'b0;
            end else if (advance) begin
                pc_reg   <= pc_advance;
                pend_reg <= 1'b0;
            end else if (branch_flag_i) begin
                pend_reg        <= 1'b1;
                pend_target_reg <= branch_target_addr_i;
            end

            // Latch the request address so a flush during S_AR cannot
            // disturb it before the handshake.
            if ((state_reg == S_IDLE) && (state_next == S_AR)) begin
                araddr_reg <= pc_reg;
            end

            // Completion of the read always retires kill; a flush while the
            // read is outstanding marks its data stale.
            if ((state_reg == S_R) && axi.m_rvalid) begin
                kill_reg <= 1'b0;
            end else if (flush && ((state_reg == S_AR) || (state_reg == S_R))) begin
                kill_reg <= 1'b1;
            end

            // Presented instruction changes only on S_HOLD entry and exit.
            if (hold_entry) begin
                if (state_reg == S_IDLE) begin
                    if_pc_reg <= pc_reg;
                    inst_reg  <= 32'd0;
                    err_reg   <= 1'b1;
                end else begin
                    if_pc_reg <= araddr_reg;
                    inst_reg  <= rsp_err ? 32'd0 : axi.m_rdata;
                    err_reg   <= rsp_err;
                end
            end else if (hold_exit) begin
                inst_reg <= 32'd0;
                err_reg  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_axi.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_axi
//   Directed bench for if_fetch_axi with a small AXI-Lite slave whose AR and
//   R latencies, data and response code are set by the stimulus sequence.
// ---------------------------------------------------------------------------
module tb_if_fetch_axi;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_addr_i;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_fetch_err;
    logic        stallreq_if;

    if_fetch_axi_if axi_bus ();

    if_fetch_axi dut (
        .clk                  (clk),
        .rst                  (rst),
        .stall                (stall),
        .flush                (flush),
        .new_pc               (new_pc),
        .branch_flag_i        (branch_flag_i),
        .branch_target_addr_i (branch_target_addr_i),
        .axi                  (axi_bus.master),
        .if_pc                (if_pc),
        .if_inst              (if_inst),
        .if_fetch_err         (if_fetch_err),
        .stallreq_if          (stallreq_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- slave model configuration ----------------
    int          ar_wait_cfg;
    int          r_wait_cfg;
    logic [31:0] rdata_cfg;
    logic [1:0]  rresp_cfg;
    int          ar_hs_count;

    // ---------------- checking ----------------
    int n_checks;
    int n_pass;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- AXI-Lite slave ----------------
    // Handshakes are observed at the falling edge; responses are driven
    // just after the rising edge.
    initial begin
        logic        hs_ar;
        logic        hs_r;
        logic [31:0] hs_addr;
        int          ar_cnt;
        int          r_cnt;
        logic        r_busy;
        axi_bus.m_arready = 1'b0;
        axi_bus.m_rvalid  = 1'b0;
        axi_bus.m_rdata   = 32'd0;
        axi_bus.m_rresp   = 2'b00;
        ar_hs_count = 0;
        ar_cnt = 0;
        r_cnt  = 0;
        r_busy = 1'b0;
        forever begin
            @(negedge clk);
            hs_ar   = axi_bus.m_arvalid && axi_bus.m_arready;
            hs_r    = axi_bus.m_rvalid && axi_bus.m_rready;
            hs_addr = axi_bus.m_araddr;
            @(posedge clk);
            #1;
            if (!rst) begin
                axi_bus.m_arready = 1'b0;
                axi_bus.m_rvalid  = 1'b0;
                r_busy = 1'b0;
                ar_cnt = 0;
                r_cnt  = 0;
            end else begin
                if (hs_r) begin
                    axi_bus.m_rvalid = 1'b0;
                end
                if (hs_ar) begin
                    axi_bus.m_arready = 1'b0;
                    r_busy = 1'b1;
                    r_cnt  = 0;
                    ar_cnt = 0;
                    ar_hs_count++;
                    $display("[%0t] AR transaction addr=%h", $time, hs_addr);
                end else if (axi_bus.m_arvalid && !axi_bus.m_arready) begin
                    if (ar_cnt >= ar_wait_cfg) axi_bus.m_arready = 1'b1;
                    else ar_cnt++;
                end
                if (r_busy && !axi_bus.m_rvalid) begin
                    if (r_cnt >= r_wait_cfg) begin
                        axi_bus.m_rvalid = 1'b1;
                        axi_bus.m_rdata  = rdata_cfg;
                        axi_bus.m_rresp  = rresp_cfg;
                        r_busy = 1'b0;
                    end else begin
                        r_cnt++;
                    end
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int hs_before;
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        stall = 6'd0;
        flush = 1'b0;
        new_pc = 32'd0;
        branch_flag_i = 1'b0;
        branch_target_addr_i = 32'd0;
        ar_wait_cfg = 0;
        r_wait_cfg  = 0;
        rdata_cfg   = 32'h2408_0001;
        rresp_cfg   = 2'b00;
        #1 rst = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #2;
        chk("rst_arvalid",  {31'd0, axi_bus.m_arvalid}, 32'd0);
        chk("rst_rready",   {31'd0, axi_bus.m_rready},  32'd0);
        chk("rst_inst",     if_inst, 32'd0);
        chk("rst_err",      {31'd0, if_fetch_err}, 32'd0);
        chk("rst_stallreq", {31'd0, stallreq_if},  32'd1);
        chk("rst_if_pc",    if_pc, 32'hBFC0_0000);
        chk("rst_arprot",   {29'd0, axi_bus.m_arprot}, 32'd4);

        // Zero-wait first fetch: cycle 1 S_IDLE
        rst = 1'b1;
        tick();   // cycle 2: S_AR
        chk("c2_arvalid",  {31'd0, axi_bus.m_arvalid}, 32'd1);
        chk("c2_araddr",   axi_bus.m_araddr, 32'hBFC0_0000);
        chk("c2_stallreq", {31'd0, stallreq_if}, 32'd1);
        tick();   // cycle 3: S_R
        chk("c3_rready",   {31'd0, axi_bus.m_rready}, 32'd1);
        chk("c3_inst",     if_inst, 32'd0);
        tick();   // cycle 4: S_HOLD
        chk("c4_inst",     if_inst, 32'h2408_0001);
        chk("c4_stallreq", {31'd0, stallreq_if}, 32'd0);
        chk("c4_if_pc",    if_pc, 32'hBFC0_0000);
        chk("c4_err",      {31'd0, if_fetch_err}, 32'd0);

        // AR delayed by 3 cycles
        rdata_cfg   = 32'h3C01_A000;
        ar_wait_cfg = 3;
        tick();   // S_IDLE
        chk("idle_stallreq", {31'd0, stallreq_if}, 32'd1);
        chk("idle_inst",     if_inst, 32'd0);
        tick();   // S_AR, first cycle
        for (int i = 0; i < 4; i++) begin
            chk("dly_arvalid",  {31'd0, axi_bus.m_arvalid}, 32'd1);
            chk("dly_araddr",   axi_bus.m_araddr, 32'hBFC0_0004);
            chk("dly_stallreq", {31'd0, stallreq_if}, 32'd1);
            if (i < 3) chk("dly_arready", {31'd0, axi_bus.m_arready}, 32'd0);
            tick();
        end
        ar_wait_cfg = 0;
        chk("dly_rready", {31'd0, axi_bus.m_rready}, 32'd1);
        tick();   // S_HOLD
        chk("dly_inst",  if_inst, 32'h3C01_A000);
        chk("dly_if_pc", if_pc, 32'hBFC0_0004);

        // Branch during delay-slot fetch of BFC00008
        rdata_cfg = 32'h0040_0008;
        tick();   // S_IDLE
        tick();   // S_AR
        chk("br_ds_araddr", axi_bus.m_araddr, 32'hBFC0_0008);
        branch_flag_i = 1'b1;
        branch_target_addr_i = 32'h8000_0100;
        tick();   // S_R
        branch_flag_i = 1'b0;
        tick();   // S_HOLD
        chk("br_ds_inst",  if_inst, 32'h0040_0008);
        chk("br_ds_if_pc", if_pc, 32'hBFC0_0008);
        tick();   // S_IDLE
        tick();   // S_AR
        chk("br_araddr", axi_bus.m_araddr, 32'h8000_0100);

        // Flush while the read is outstanding
        r_wait_cfg = 2;
        rdata_cfg  = 32'hDEAD_BEEF;
        tick();   // S_R, no data yet
        flush  = 1'b1;
        new_pc = 32'hBFC0_0380;
        tick();   // S_R, kill set
        flush  = 1'b0;
        chk("fl_rready",   {31'd0, axi_bus.m_rready}, 32'd1);
        chk("fl_stallreq", {31'd0, stallreq_if}, 32'd1);
        chk("fl_inst_a",   if_inst, 32'd0);
        tick();   // S_R, stale data returned now
        chk("fl_inst_b",   if_inst, 32'd0);
        r_wait_cfg = 0;
        rresp_cfg  = 2'b10;
        rdata_cfg  = 32'h1234_5678;
        tick();   // S_IDLE
        chk("fl_inst_c",    if_inst, 32'd0);
        chk("fl_stallreq2", {31'd0, stallreq_if}, 32'd1);
        tick();   // S_AR
        chk("fl_araddr",    axi_bus.m_araddr, 32'hBFC0_0380);

        // SLVERR response
        tick();   // S_R
        tick();   // S_HOLD
        chk("slverr_err",      {31'd0, if_fetch_err}, 32'd1);
        chk("slverr_inst",     if_inst, 32'd0);
        chk("slverr_stallreq", {31'd0, stallreq_if}, 32'd0);
        chk("slverr_if_pc",    if_pc, 32'hBFC0_0380);

        // Misaligned branch target: no AXI request
        rresp_cfg = 2'b00;
        branch_flag_i = 1'b1;
        branch_target_addr_i = 32'h8000_0102;
        hs_before = ar_hs_count;
        tick();   // S_IDLE
        branch_flag_i = 1'b0;
        chk("mis_arvalid", {31'd0, axi_bus.m_arvalid}, 32'd0);
        tick();   // S_HOLD
        chk("mis_err",      {31'd0, if_fetch_err}, 32'd1);
        chk("mis_inst",     if_inst, 32'd0);
        chk("mis_stallreq", {31'd0, stallreq_if}, 32'd0);
        chk("mis_if_pc",    if_pc, 32'h8000_0102);
        chk("mis_no_ar",    ar_hs_count, hs_before);

        // Flush from S_HOLD withdraws the presented instruction
        flush  = 1'b1;
        new_pc = 32'h8000_0200;
        tick();   // S_IDLE
        flush  = 1'b0;
        chk("hfl_inst",     if_inst, 32'd0);
        chk("hfl_err",      {31'd0, if_fetch_err}, 32'd0);
        chk("hfl_stallreq", {31'd0, stallreq_if}, 32'd1);
        rdata_cfg = 32'h2129_FFFF;
        tick();   // S_AR
        chk("hfl_araddr", axi_bus.m_araddr, 32'h8000_0200);
        tick();   // S_R
        tick();   // S_HOLD
        chk("st_inst0", if_inst, 32'h2129_FFFF);

        // stall[0] held for 5 cycles in S_HOLD
        stall = 6'b000001;
        hs_before = ar_hs_count;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("st_inst",     if_inst, 32'h2129_FFFF);
            chk("st_if_pc",    if_pc, 32'h8000_0200);
            chk("st_stallreq", {31'd0, stallreq_if}, 32'd0);
            chk("st_arvalid",  {31'd0, axi_bus.m_arvalid}, 32'd0);
        end
        chk("st_no_ar", ar_hs_count, hs_before);
        stall = 6'd0;
        tick();   // S_IDLE
        chk("st_rel_inst", if_inst, 32'd0);
        tick();   // S_AR
        chk("st_rel_araddr", axi_bus.m_araddr, 32'h8000_0204);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_axi.md
# if_fetch_axi

Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the PC and fetches one 32-bit instruction at a time over an AXI4-Lite read channel. It presents `if_pc`/`if_inst` to IF/ID and raises `stallreq_if` while a fetch is outstanding. It applies branch redirects from ID and exception redirects from the flush controller, and discards any in-flight read that a flush has made stale.

## Interface
- `RESET_PC`, 32'hBFC0_0000, PC value loaded on reset.
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall`  in  6  pipeline stall vector; bit 0 = hold PC/IF.
- `flush`  in  1  exception flush; redirect to `new_pc`.
- `new_pc`  in  32  exception/ERET target, valid with `flush`.
- `branch_flag_i`  in  1  ID resolved a taken branch/jump.
- `branch_target_addr_i`  in  32  target, valid with `branch_flag_i`.
- `m_araddr`  out  32, `m_arvalid`  out  1, `m_arready`  in  1, `m_arprot`  out  3: AXI-Lite AR channel.
- `m_rdata`  in  32, `m_rresp`  in  2, `m_rvalid`  in  1, `m_rready`  out  1: AXI-Lite R channel.
- `if_pc`  out  32  PC of the presented instruction.
- `if_inst`  out  32  fetched instruction; 0 (NOP) when not valid.
- `if_fetch_err`  out  1  misaligned PC or non-OKAY response for `if_pc`.
- `stallreq_if`  out  1  fetch not complete; stall controller must freeze IF/ID.

## Operation
- State machine: S_IDLE, S_AR, S_R, S_HOLD.
- Reset state: S_IDLE, `pc` = RESET_PC, kill = 0, pend = 0.
  - Outputs during reset: `m_arvalid` = 0, `m_rready` = 0, `if_inst` = 0, `if_fetch_err` = 0, `stallreq_if` = 1.
  - `if_pc` = RESET_PC.
  - `m_arprot` = 3'b100, constant.
- S_IDLE: next cycle → S_AR. If `pc[1:0]` != 0, go to S_HOLD instead, with err = 1 and inst = 0.
- S_AR: `m_arvalid` = 1, `m_araddr` = `pc`. Address is held stable until `m_arready`, then → S_R.
- S_R: `m_rready` = 1. On `m_rvalid`:
  - kill = 1: drop data, clear kill, → S_IDLE.
  - kill = 0: latch `m_rdata`, set err = (`m_rresp` != 2'b00), → S_HOLD. Latched inst is 0 when err = 1.
- S_HOLD: `if_inst`/`if_fetch_err` valid and `stallreq_if` = 0.
  - Stays in S_HOLD while `stall[0]` = 1.
  - When `stall[0]` = 0: advance `pc`, → S_IDLE.
- `stallreq_if` = 1 in S_IDLE, S_AR and S_R. `if_inst` = 0 outside S_HOLD.
- Next-PC priority on advance:
  1. `branch_flag_i` this cycle → `branch_target_addr_i`.
  2. pend = 1 → pend_target.
  3. Otherwise `pc` + 4, wrapping mod 2^32.
  - pend is cleared on advance.
- Branch capture: `branch_flag_i` = 1 in any non-advancing cycle sets pend = 1 and pend_target = target; a later assertion overwrites. The instruction fetched at `pc` is the delay slot and is always delivered.
- Flush (highest priority, any state): `pc` ← `new_pc`, pend ← 0.
  - S_AR: keep `m_arvalid` and the old `m_araddr` until handshake (AXI rule), set kill, → S_R.
  - S_R: set kill; stay in S_R until `m_rvalid`.
  - S_HOLD or S_IDLE: → S_IDLE; presented instruction is withdrawn next cycle.
  - Flush with simultaneous `m_rvalid` in S_R: data discarded, → S_IDLE.
  - Flush with simultaneous `branch_flag_i`: flush wins, branch ignored.
- Reset asserted mid-transaction: everything returns to reset values asynchronously. The AXI slave shares `rst`; no outstanding read survives.

## Timing
- Zero-wait slave (`m_arready` = 1 in S_AR, `m_rvalid` the following cycle): S_IDLE, S_AR, S_R, S_HOLD. First instruction is valid 4 cycles after reset release; steady state is one instruction per 4 cycles.
- Each cycle of `m_arready` or `m_rvalid` delay adds one cycle.
- `if_pc`/`if_inst` are registered and change only on S_HOLD entry/exit or reset.
- `stallreq_if` is registered from state, with no combinational path from AXI inputs.

## Test plan
- Reset, zero-wait slave returning `m_rdata` = 32'h2408_0001:
  - AR issued with `m_araddr` = BFC00000 on cycle 2.
  - `if_inst` = 24080001 and `stallreq_if` = 0 on cycle 4.
  - Next `m_araddr` = BFC00004.
- `m_arready` delayed 3 cycles: `m_araddr` stays stable, `m_arvalid` stays high, `stallreq_if` stays 1 throughout.
- `branch_flag_i` with target 8000_0100 while fetching BFC00008: BFC00008 (delay slot) is delivered, then `m_araddr` = 80000100.
- `flush` with `new_pc` = BFC00380 during S_R: returned data is never presented; next AR = BFC00380.
- `m_rresp` = 2'b10 → `if_fetch_err` = 1, `if_inst` = 0. Misaligned branch target 8000_0102 → `if_fetch_err` = 1 with no AXI request.
- `stall[0]` held 5 cycles in S_HOLD: `if_inst` and `if_pc` stay constant, and no new AR is issued.
